// File: rtl/mcyc_pkg.sv
// Shared types and encodings for the multi-cycle RV32I sequencer.
// Optional TRAP state exists only when MCYC_TRAP_EN is defined.
package mcyc_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [1:0] ALU_ADD    = 2'b00;
    localparam logic [1:0] ALU_BRANCH = 2'b01;
    localparam logic [1:0] ALU_RTYPE  = 2'b10;
    localparam logic [1:0] ALU_ITYPE  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB
`ifdef MCYC_TRAP_EN
        , ST_TRAP
`endif
    } state_e;

    typedef enum logic [2:0] {
        CLS_ALU,
        CLS_LOAD,
        CLS_STORE,
        CLS_BRANCH,
        CLS_JUMP
    } op_class_e;

endpackage

// File: rtl/mcyc_opdecode.sv
// Combinational opcode classifier; the sequencer gates these fields per state.
module mcyc_opdecode import mcyc_pkg::*; (
    input  logic [6:0] op_i,
    output logic       legal_o,
    output op_class_e  op_class_o,
    output logic [1:0] alu_op_o,
    output logic       alu_src_o,
    output logic       upper_imm_o,
    output logic       pc_return_o
);

    always_comb begin
        legal_o     = 1'b1;
        op_class_o  = CLS_ALU;
        alu_op_o    = ALU_ADD;
        alu_src_o   = 1'b1;
        upper_imm_o = 1'b0;
        pc_return_o = 1'b0;
        case (op_i)
            OP_R: begin
                alu_op_o  = ALU_RTYPE;
                alu_src_o = 1'b0;
            end
            OP_I:     alu_op_o = ALU_ITYPE;
            OP_LOAD:  op_class_o = CLS_LOAD;
            OP_STORE: op_class_o = CLS_STORE;
            OP_BRANCH: begin
                op_class_o = CLS_BRANCH;
                alu_op_o   = ALU_BRANCH;
                alu_src_o  = 1'b0;
            end
            OP_LUI:   upper_imm_o = 1'b1;
            OP_AUIPC: ;
            OP_JAL: begin
                op_class_o = CLS_JUMP;
                alu_op_o   = ALU_RTYPE;
            end
            OP_JALR: begin
                op_class_o  = CLS_JUMP;
                alu_op_o    = ALU_RTYPE;
                pc_return_o = 1'b1;
            end
            default: begin
                legal_o   = 1'b0;
                alu_src_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore sequencer stepping RV32I instructions through FETCH/DECODE/EXEC/MEM/WB
// over a shared req/ready memory port. MCYC_TRAP_EN adds a sticky TRAP state.
module multicycle_ctrl import mcyc_pkg::*; #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       opcode_i,
    input  logic             mem_ready_i,
    output logic             mem_req_o,
    output logic             mem_we_o,
    output logic             ir_write_o,
    output logic             pc_write_o,
    output logic             reg_write_o,
    output logic             mem_to_reg_o,
    output logic             alu_src_o,
    output logic             branch_o,
    output logic             upper_imm_o,
    output logic             pc_sel_o,
    output logic             pc_return_o,
    output logic             jump_o,
    output logic [1:0]       alu_op_o,
    output logic [CNT_W-1:0] retired_o
`ifdef MCYC_TRAP_EN
    ,
    output logic             illegal_o
`endif
);

    state_e           state_q, state_d;
    logic [6:0]       op_q, op_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             retire;

    logic             dec_legal;
    op_class_e        dec_class;
    logic [1:0]       dec_alu_op;
    logic             dec_alu_src;
    logic             dec_upper_imm;
    logic             dec_pc_return;
    logic [6:0]       dec_op;

    // Legality is judged on the live opcode in DECODE; everywhere else only op_q matters.
    assign dec_op = (state_q == ST_DECODE) ? opcode_i : op_q;

    mcyc_opdecode u_opdecode (
        .op_i        (dec_op),
        .legal_o     (dec_legal),
        .op_class_o  (dec_class),
        .alu_op_o    (dec_alu_op),
        .alu_src_o   (dec_alu_src),
        .upper_imm_o (dec_upper_imm),
        .pc_return_o (dec_pc_return)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            op_q      <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            retired_q <= retired_d;
        end
    end

    assign retired_d = retire ? retired_q + CNT_W'(1) : retired_q;
    assign retired_o = retired_q;

`ifdef MCYC_TRAP_EN
    logic illegal_q, illegal_d;

    assign illegal_d = illegal_q | ((state_q == ST_DECODE) && !dec_legal);
    assign illegal_o = illegal_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) illegal_q <= 1'b0;
        else        illegal_q <= illegal_d;
    end
`endif

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        retire       = 1'b0;
        mem_req_o    = 1'b0;
        mem_we_o     = 1'b0;
        ir_write_o   = 1'b0;
        pc_write_o   = 1'b0;
        reg_write_o  = 1'b0;
        mem_to_reg_o = 1'b0;
        alu_src_o    = 1'b0;
        branch_o     = 1'b0;
        upper_imm_o  = 1'b0;
        pc_sel_o     = 1'b0;
        pc_return_o  = 1'b0;
        jump_o       = 1'b0;
        alu_op_o     = ALU_ADD;
        unique case (state_q)
            ST_IDLE: state_d = ST_FETCH;
            ST_FETCH: begin
                mem_req_o = 1'b1;
                if (mem_ready_i) begin
                    ir_write_o = 1'b1;
                    pc_write_o = 1'b1;
                    state_d    = ST_DECODE;
                end
            end
            ST_DECODE: begin
                op_d = opcode_i;
                if (dec_legal) state_d = ST_EXEC;
`ifdef MCYC_TRAP_EN
                else           state_d = ST_TRAP;
`else
                else           state_d = ST_FETCH;
`endif
            end
            ST_EXEC: begin
                alu_op_o    = dec_alu_op;
                alu_src_o   = dec_alu_src;
                upper_imm_o = dec_upper_imm;
                case (dec_class)
                    CLS_LOAD, CLS_STORE: state_d = ST_MEM;
                    CLS_BRANCH: begin
                        branch_o = 1'b1;
                        retire   = 1'b1;
                        state_d  = ST_FETCH;
                    end
                    CLS_JUMP: begin
                        jump_o      = 1'b1;
                        pc_sel_o    = 1'b1;
                        pc_return_o = dec_pc_return;
                        state_d     = ST_WB;
                    end
                    default: state_d = ST_WB;
                endcase
            end
            ST_MEM: begin
                mem_req_o = 1'b1;
                mem_we_o  = (dec_class == CLS_STORE);
                if (mem_ready_i) begin
                    if (dec_class == CLS_STORE) begin
                        retire  = 1'b1;
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_WB;
                    end
                end
            end
            ST_WB: begin
                reg_write_o  = 1'b1;
                mem_to_reg_o = (dec_class == CLS_LOAD);
                if (dec_class == CLS_JUMP) begin
                    jump_o      = 1'b1;
                    pc_sel_o    = 1'b1;
                    pc_return_o = dec_pc_return;
                end
                retire  = 1'b1;
                state_d = ST_FETCH;
            end
`ifdef MCYC_TRAP_EN
            ST_TRAP: state_d = ST_TRAP;
`endif
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized self-checking bench for multicycle_ctrl; expectations come from a
// per-instruction phase model (FETCH waits, EXEC/MEM/WB control table).
module tb_multicycle_ctrl;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  opcode_i;
    logic        mem_ready_i;
    logic        mem_req_o, mem_we_o, ir_write_o, pc_write_o, reg_write_o, mem_to_reg_o;
    logic        alu_src_o, branch_o, upper_imm_o, pc_sel_o, pc_return_o, jump_o;
    logic [1:0]  alu_op_o;
    logic [31:0] retired_o;
`ifdef MCYC_TRAP_EN
    logic        illegal_o;
`endif

    int          vectors = 0;
    int          miscompares = 0;
    int unsigned expRetired = 0;
    logic [6:0]  legalOps [9] = '{OPC_R, OPC_I, OPC_LOAD, OPC_STORE, OPC_BRANCH,
                                  OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR};

    always #5 clk = ~clk;

    multicycle_ctrl #(.CNT_W(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .opcode_i     (opcode_i),
        .mem_ready_i  (mem_ready_i),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .ir_write_o   (ir_write_o),
        .pc_write_o   (pc_write_o),
        .reg_write_o  (reg_write_o),
        .mem_to_reg_o (mem_to_reg_o),
        .alu_src_o    (alu_src_o),
        .branch_o     (branch_o),
        .upper_imm_o  (upper_imm_o),
        .pc_sel_o     (pc_sel_o),
        .pc_return_o  (pc_return_o),
        .jump_o       (jump_o),
        .alu_op_o     (alu_op_o),
        .retired_o    (retired_o)
`ifdef MCYC_TRAP_EN
        ,
        .illegal_o    (illegal_o)
`endif
    );

    function automatic logic [13:0] ctrl(input bit req, we, irw, pcw, rw, m2r, asrc,
                                         br, uimm, psel, pret, jmp,
                                         input logic [1:0] aop);
        return {req, we, irw, pcw, rw, m2r, asrc, br, uimm, psel, pret, jmp, aop};
    endfunction

    function automatic logic [13:0] observedCtrl();
        return {mem_req_o, mem_we_o, ir_write_o, pc_write_o, reg_write_o, mem_to_reg_o,
                alu_src_o, branch_o, upper_imm_o, pc_sel_o, pc_return_o, jump_o, alu_op_o};
    endfunction

    function automatic bit isLegal(input logic [6:0] op);
        return op inside {OPC_R, OPC_I, OPC_LOAD, OPC_STORE, OPC_BRANCH,
                          OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s observed=%h expected=%h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Drive one cycle's inputs, check outputs and counter mid-cycle, then advance.
    task automatic applyStimulus(input string tag, input logic [13:0] expCtrl,
                                 input logic ready, input logic [6:0] op);
        mem_ready_i = ready;
        opcode_i    = op;
        @(negedge clk);
        checkOutput({tag, ".ctrl"}, 32'(observedCtrl()), 32'(expCtrl));
        checkOutput({tag, ".retired"}, retired_o, expRetired);
        @(posedge clk);
        #1;
    endtask

    task automatic runInstr(input logic [6:0] op, input int fetchWaits, input int memWaits);
        logic [1:0] aop;
        bit asrc, uimm, br, jmp, pret, isLoad, isStore;
        for (int i = 0; i <= fetchWaits; i++) begin
            bit rdy;
            rdy = (i == fetchWaits);
            applyStimulus("fetch", ctrl(1, 0, rdy, rdy, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00),
                          rdy, 7'($urandom));
        end
        applyStimulus("decode", 14'd0, 1'($urandom_range(0, 1)), op);
        if (!isLegal(op)) return;

        aop = 2'b00; asrc = 1; uimm = 0; br = 0; jmp = 0; pret = 0;
        isLoad  = (op == OPC_LOAD);
        isStore = (op == OPC_STORE);
        case (op)
            OPC_R:      begin aop = 2'b10; asrc = 0; end
            OPC_I:      aop = 2'b11;
            OPC_LUI:    uimm = 1;
            OPC_BRANCH: begin aop = 2'b01; asrc = 0; br = 1; end
            OPC_JAL:    begin aop = 2'b10; jmp = 1; end
            OPC_JALR:   begin aop = 2'b10; jmp = 1; pret = 1; end
            default: ;
        endcase
        applyStimulus("exec", ctrl(0, 0, 0, 0, 0, 0, asrc, br, uimm, jmp, pret, jmp, aop),
                      1'($urandom_range(0, 1)), 7'($urandom));
        if (br) begin
            expRetired++;
            return;
        end

        if (isLoad || isStore) begin
            for (int i = 0; i <= memWaits; i++) begin
                bit rdy;
                rdy = (i == memWaits);
                applyStimulus("mem", ctrl(1, isStore, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00),
                              rdy, 7'($urandom));
            end
            if (isStore) begin
                expRetired++;
                return;
            end
        end

        applyStimulus("wb", ctrl(0, 0, 0, 0, 1, isLoad, 0, 0, 0, jmp, pret, jmp, 2'b00),
                      1'($urandom_range(0, 1)), 7'($urandom));
        expRetired++;
    endtask

    initial begin
        rst_n       = 1'b0;
        mem_ready_i = 1'b0;
        opcode_i    = 7'd0;
        #12;
        checkOutput("reset.ctrl", 32'(observedCtrl()), 32'd0);
        checkOutput("reset.retired", retired_o, 32'd0);
`ifdef MCYC_TRAP_EN
        checkOutput("reset.illegal", 32'(illegal_o), 32'd0);
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        applyStimulus("idle", 14'd0, 1'b1, 7'($urandom));

        runInstr(OPC_R, 0, 0);
        runInstr(OPC_LOAD, 3, 2);
        runInstr(OPC_STORE, 0, 0);
        runInstr(OPC_BRANCH, 0, 0);
        runInstr(OPC_JALR, 0, 0);
`ifndef MCYC_TRAP_EN
        runInstr(7'b1111111, 1, 0);
        runInstr(OPC_AUIPC, 0, 0);
`endif

        for (int n = 0; n < 300; n++) begin
            logic [6:0] op;
            op = legalOps[$urandom_range(0, 8)];
`ifndef MCYC_TRAP_EN
            if ($urandom_range(0, 9) == 0) begin
                op = 7'($urandom);
                if (isLegal(op)) op = 7'b1111111;
            end
`endif
            runInstr(op, $urandom_range(0, 3), $urandom_range(0, 3));
        end

        // Abort a load in MEM while its request is outstanding.
        applyStimulus("abort.fetch", ctrl(1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00), 1'b1, 7'($urandom));
        applyStimulus("abort.decode", 14'd0, 1'b0, OPC_LOAD);
        applyStimulus("abort.exec", ctrl(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 2'b00), 1'b0, 7'($urandom));
        applyStimulus("abort.mem", ctrl(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00), 1'b0, 7'($urandom));
        mem_ready_i = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        expRetired = 0;
        checkOutput("abort.async.ctrl", 32'(observedCtrl()), 32'd0);
        checkOutput("abort.async.retired", retired_o, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        applyStimulus("abort.idle", 14'd0, 1'b1, 7'($urandom));
        runInstr(OPC_R, 0, 0);

`ifdef MCYC_TRAP_EN
        runInstr(7'b1111111, 0, 0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus("trap", 14'd0, 1'($urandom_range(0, 1)), 7'($urandom));
            checkOutput("trap.illegal", 32'(illegal_o), 32'd1);
        end
        #2;
        rst_n = 1'b0;
        #1;
        expRetired = 0;
        checkOutput("trap.reset.illegal", 32'(illegal_o), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        applyStimulus("trap.idle", 14'd0, 1'b1, 7'($urandom));
        runInstr(OPC_JAL, 1, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle sequencer for the RV32I datapath. It replaces single-cycle control with a Moore FSM that steps each instruction through FETCH/DECODE/EXEC/MEM/WB. It shares one variable-latency memory port between instruction fetch and load/store through a req/ready handshake, and drives the same datapath control set as the combinational decoder. It sits between the instruction register and the datapath muxes/ALU, and keeps a retired-instruction counter.

## Interface
- CNT_W, 32, width of retired-instruction counter
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- opcode  in  7  instr[6:0] from instruction register, sampled in DECODE
- mem_ready  in  1  memory completes current request this cycle
- mem_req  out  1  memory request, held until mem_ready
- mem_we  out  1  write qualifier, valid while mem_req
- ir_write  out  1  load instruction register (fetch accept cycle)
- pc_write  out  1  PC <= PC+4 (fetch accept cycle)
- reg_write, mem_to_reg, alu_src, branch, upper_imm, pc_sel, pc_return, jump  out  1 each  datapath controls
- alu_op  out  2  00 add, 01 branch compare, 10 R-type/jump, 11 I-type ALU
- retired  out  CNT_W  instructions completed since reset
- illegal  out  1  (MCYC_TRAP_EN only) sticky illegal-opcode flag

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB (+TRAP).
- IDLE: one cycle after reset release, all controls 0, then FETCH.
- FETCH: mem_req=1, mem_we=0. Stay until mem_ready. On the ready cycle: ir_write=1, pc_write=1, then DECODE.
- DECODE: latch opcode into op_q, all controls 0. Legal opcode -> EXEC. Illegal opcode -> TRAP if enabled, else FETCH as NOP (not counted).
- Legal opcodes: 0110011 R, 0010011 I-ALU, 0000011 load, 0100011 store, 1100011 branch, 0110111 LUI, 0010111 AUIPC, 1101111 JAL, 1100111 JALR.
- EXEC drives ALU controls from op_q:
  - R: alu_op=10, alu_src=0 -> WB
  - I: 11/1 -> WB
  - load/store: 00/1 -> MEM
  - LUI: 00/1 with upper_imm=1 -> WB
  - AUIPC: 00/1 -> WB
  - branch: 01/0 with branch=1 for exactly one cycle -> FETCH
  - JAL: 10/1, jump=1, pc_sel=1 -> WB
  - JALR: same as JAL plus pc_return=1 -> WB
- MEM: mem_req=1, mem_we=1 for store only. Hold until mem_ready. On ready: load -> WB, store -> FETCH.
- WB: reg_write=1 for one cycle; mem_to_reg=1 for load; jump/pc_sel/pc_return held for JAL/JALR. Then FETCH.
- retired increments by 1 on the last cycle of each legal instruction:
  - WB exit
  - store MEM-ready cycle
  - branch EXEC cycle
- retired wraps modulo 2^CNT_W.
- Any control not listed for a state is 0. Controls are glitch-free functions of state and op_q only; mem_ready affects only ir_write/pc_write and transitions.

## Timing
- Reset (async assert, sync release): state=IDLE, op_q=0, retired=0, illegal=0; all outputs 0.
- Zero-wait latency (FETCH through last state): R/I/LUI/AUIPC/JAL/JALR 4 cycles, load 5, store 4, branch 3. Each mem_ready-low cycle adds 1.
- Requests: mem_req rises only on entering FETCH or MEM. It never drops before mem_ready. mem_we is stable for the whole request.
- mem_ready while mem_req=0 is ignored.
- Back-to-back: the WB/branch/store exit cycle is followed directly by FETCH with mem_req=1; no idle bubble.
- Reset mid-request: mem_req drops immediately (async). The counter is not incremented for the aborted instruction.

## Configuration
- MCYC_TRAP_EN defined:
  - DECODE with an illegal opcode -> TRAP.
  - TRAP: all controls 0, illegal=1 (sticky). Exit only by reset.
- MCYC_TRAP_EN undefined:
  - No TRAP state and no illegal port.
  - Illegal opcodes return DECODE -> FETCH, counted as nothing.

## Structure
- Package mcyc_pkg holds:
  - state enum typedef
  - opcode localparams (OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR)
  - alu_op encoding localparams
- Sub-module mcyc_opdecode: combinational. Maps op_q to legal, class (alu/load/store/branch/jump), alu_op, alu_src, upper_imm, pc_return. The FSM gates its outputs per state.

## Test plan
- Reset, then R-type 0110011 with mem_ready always 1: IDLE, F, D, E(alu_op=10), WB(reg_write=1), F. retired=1 after 5 cycles.
- Load 0000011, mem_ready low 3 cycles in FETCH and 2 in MEM: mem_req held steady in both; WB has mem_to_reg=1. Total 10 cycles; retired +1.
- Store then branch back-to-back: store MEM mem_we=1 for 1 cycle; branch=1 exactly one cycle in EXEC. retired +2; no cycle with mem_req=0 between FETCHes except D/E.
- JALR 1100111: EXEC and WB show jump=1, pc_sel=1, pc_return=1; WB reg_write=1.
- Opcode 1111111: with MCYC_TRAP_EN, illegal=1 and FSM stuck until rst_n low. Without it, FETCH follows DECODE and retired is unchanged.
- rst_n low mid-MEM with mem_req=1: all outputs 0 asynchronously; after release, IDLE then FETCH; retired=0.
